// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the dual-clock FIFO. It pops words, absorbs the FIFO's
// one-cycle registered read latency in a 3-entry skid buffer, and presents a valid/ready stream.
module fifo_stream_reader #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_out,
  output logic              rd_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              busy
);

  localparam int DEPTH = 3;

  logic [1:0]       r_head, r_head_next;
  logic [1:0]       r_tail, r_tail_next;
  logic [1:0]       r_occ, r_occ_next;
  logic             r_inflight;
  logic [CNT_W-1:0] r_word_cnt, r_word_cnt_next;

  logic [2:0] w_committed;
  logic       w_credit;
  logic       w_rd_en;
  logic       w_arrive;
  logic       w_valid;
  logic       w_xfer;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit counts both buffered words and the word still coming out of the FIFO,
  // so an arrival always finds a free slot and rd_en never looks at m_ready.
  assign w_committed = {1'b0, r_occ} + {2'b00, r_inflight};
  assign w_credit    = (w_committed < 3'd3);
  assign w_rd_en     = en && !fifo_empty && !rd_rst && w_credit;
  assign w_arrive    = r_inflight;
  assign w_valid     = (r_occ != 2'd0) && !rd_rst;
  assign w_xfer      = w_valid && m_ready;

  always_comb begin
    r_head_next     = r_head;
    r_tail_next     = r_tail;
    r_occ_next      = r_occ;
    r_word_cnt_next = r_word_cnt;
    if (w_arrive) begin
      r_tail_next = ptr_inc(r_tail);
    end
    if (w_xfer) begin
      r_head_next     = ptr_inc(r_head);
      r_word_cnt_next = r_word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    case ({w_arrive, w_xfer})
      2'b10:   r_occ_next = r_occ + 2'd1;
      2'b01:   r_occ_next = r_occ - 2'd1;
      default: r_occ_next = r_occ;
    endcase
  end

  // A word in flight at reset is dropped simply by not advancing tail/occ.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_head     <= 2'd0;
      r_tail     <= 2'd0;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_head     <= r_head_next;
      r_tail     <= r_tail_next;
      r_occ      <= r_occ_next;
      r_inflight <= w_rd_en;
      r_word_cnt <= r_word_cnt_next;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_buf
      logic [DATA_W-1:0] r_word;
      always_ff @(posedge rd_clk) begin
        if (w_arrive && !rd_rst && (r_tail == 2'(gi))) begin
          r_word <= fifo_out;
        end
      end
    end
  endgenerate

  always_comb begin
    case (r_head)
      2'd0:    m_data = g_buf[0].r_word;
      2'd1:    m_data = g_buf[1].r_word;
      default: m_data = g_buf[2].r_word;
    endcase
  end

  assign rd_en    = w_rd_en;
  assign m_valid  = w_valid;
  assign word_cnt = r_word_cnt;
  assign busy     = ((r_occ != 2'd0) || r_inflight) && !rd_rst;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: behavioural FIFO with registered read,
// scoreboard of pushed words checked in order at every stream transfer.
module tb_fifo_stream_reader;

  logic        rd_clk = 1'b0;
  logic        rd_rst = 1'b1;
  logic        en = 1'b1;
  logic        m_ready = 1'b1;
  logic        fifo_empty;
  logic [7:0]  fifo_out;
  logic        rd_en, m_valid, busy;
  logic [7:0]  m_data;
  logic [15:0] word_cnt;
  logic        w4_rd_en, w4_m_valid, w4_busy;
  logic [7:0]  w4_m_data;
  logic [3:0]  w4_word_cnt;

  logic [7:0] fifo_mem [256];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [7:0] sb [$];
  int         errors = 0;
  int         checks = 0;
  int         pops = 0;

  fifo_stream_reader #(.DATA_W(8), .CNT_W(16)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .en(en), .fifo_empty(fifo_empty),
    .fifo_out(fifo_out), .rd_en(rd_en), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .word_cnt(word_cnt), .busy(busy)
  );

  fifo_stream_reader #(.DATA_W(8), .CNT_W(4)) dut4 (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .en(en), .fifo_empty(fifo_empty),
    .fifo_out(fifo_out), .rd_en(w4_rd_en), .m_data(w4_m_data), .m_valid(w4_m_valid),
    .m_ready(m_ready), .word_cnt(w4_word_cnt), .busy(w4_busy)
  );

  always #5 rd_clk = ~rd_clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge rd_clk) begin
    if (rd_en) begin
      fifo_out <= fifo_mem[rd_ptr[7:0]];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic neg();
    @(negedge rd_clk);
  endtask

  task automatic push(input logic [7:0] d);
    fifo_mem[wr_ptr[7:0]] = d;
    wr_ptr++;
    sb.push_back(d);
  endtask

  task automatic drain(input int max, input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy || rd_en) && n < max) begin
      next();
      neg();
      n++;
    end
    chk({tag, "_drain_in_time"}, 32'(n < max), 1);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  // Monitor: credit invariant and in-order delivery at every accepted transfer.
  always @(negedge rd_clk) begin
    logic [7:0] exp_d;
    if (rd_en) pops++;
    if (!rd_rst) begin
      chk("no_arrival_when_full", 32'(!(dut.r_inflight && dut.r_occ == 2'd3)), 1);
      if (m_valid && m_ready) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL stream_extra_word: observed=%0h expected=no word", m_data);
        end
        if (sb.size() != 0) begin
          exp_d = sb.pop_front();
          chk("stream_data", m_data, exp_d);
        end
      end
    end
  end

  initial begin
    int p0;
    int gaps;
    int stable;

    // Reset held two cycles with the FIFO non-empty.
    push(8'hA5);
    neg();
    chk("rst_rd_en_c0", rd_en, 0);
    neg();
    chk("rst_rd_en_c1", rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);

    // Single word: rd_en in N, m_valid only in N+2.
    next(); rd_rst = 1'b0;
    neg();
    chk("post_rst_word_cnt", word_cnt, 0);
    chk("post_rst_m_valid", m_valid, 0);
    chk("post_rst_busy", busy, 0);
    chk("single_rd_en_n", rd_en, 1);
    next(); neg();
    chk("single_rd_en_n1", rd_en, 0);
    chk("single_m_valid_n1", m_valid, 0);
    chk("single_busy_n1", busy, 1);
    next(); neg();
    chk("single_m_valid_n2", m_valid, 1);
    chk("single_m_data_n2", m_data, 8'hA5);
    next(); neg();
    chk("single_m_valid_n3", m_valid, 0);
    chk("single_busy_n3", busy, 0);
    chk("single_word_cnt", word_cnt, 1);

    // Throughput: 64 words, no bubbles.
    next();
    p0 = pops;
    for (int i = 0; i < 64; i++) push(8'(i));
    neg();
    chk("thru_rd_en_first", rd_en, 1);
    next(); neg();
    chk("thru_latency_m_valid", m_valid, 0);
    gaps = 0;
    for (int i = 0; i < 64; i++) begin
      next(); neg();
      if (m_valid !== 1'b1) gaps++;
    end
    chk("thru_gaps", gaps, 0);
    next(); neg();
    chk("thru_m_valid_end", m_valid, 0);
    chk("thru_busy_end", busy, 0);
    chk("thru_pops", pops - p0, 64);
    chk("thru_fifo_empty", fifo_empty, 1);
    chk("thru_word_cnt", word_cnt, 65);

    // Backpressure: 10 words, m_ready low, exactly 3 pops and a stable head.
    next();
    m_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 10; i++) push(8'h80 + 8'(i));
    neg();
    stable = 0;
    for (int k = 1; k <= 8; k++) begin
      next(); neg();
      if (k >= 2 && m_valid === 1'b1 && m_data === 8'h80) stable++;
    end
    chk("bp_hold_stable", stable, 7);
    chk("bp_pops", pops - p0, 3);
    chk("bp_busy", busy, 1);
    next(); m_ready = 1'b1;
    neg();
    drain(40, "bp");
    chk("bp_pops_total", pops - p0, 10);
    chk("bp_word_cnt", word_cnt, 75);

    // FIFO runs empty after 5 words, refilled 7 cycles later.
    next();
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
    neg();
    for (int k = 1; k <= 7; k++) begin
      next(); neg();
    end
    chk("gap_m_valid_low", m_valid, 0);
    chk("gap_busy_low", busy, 0);
    chk("gap_word_cnt", word_cnt, 80);
    next();
    for (int i = 0; i < 5; i++) push(8'hD0 + 8'(i));
    neg();
    drain(30, "gap");
    chk("gap_word_cnt_end", word_cnt, 85);

    // en dropped mid-stream: no pops, buffer drains.
    next();
    for (int i = 0; i < 20; i++) push(8'hE0 + 8'(i));
    neg();
    for (int k = 0; k < 4; k++) begin
      next(); neg();
    end
    next(); en = 1'b0;
    p0 = pops;
    neg();
    chk("en0_rd_en", rd_en, 0);
    for (int k = 0; k < 6; k++) begin
      next(); neg();
    end
    chk("en0_no_pops", pops - p0, 0);
    chk("en0_m_valid", m_valid, 0);
    chk("en0_busy", busy, 0);
    chk("en0_occ_zero", dut.r_occ, 0);
    next(); en = 1'b1;
    neg();
    drain(60, "en");
    chk("en_word_cnt_end", word_cnt, 105);

    // Reset with occ=2 and a pop in flight; FIFO read side flushed alongside.
    next();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'hF0 + 8'(i));
    neg();
    next(); neg();
    next(); neg();
    chk("mid_busy_before_rst", busy, 1);
    chk("mid_m_valid_before_rst", m_valid, 1);
    next();
    rd_rst = 1'b1;
    wr_ptr = rd_ptr;
    sb.delete();
    neg();
    chk("mid_rst_rd_en", rd_en, 0);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    next();
    rd_rst = 1'b0;
    m_ready = 1'b1;
    neg();
    chk("mid_after_m_valid", m_valid, 0);
    chk("mid_after_busy", busy, 0);
    chk("mid_after_word_cnt", word_cnt, 0);
    chk("mid_after_word_cnt4", w4_word_cnt, 0);

    // 17 transfers: the 4-bit counter wraps to 1.
    next();
    for (int i = 0; i < 17; i++) push(8'h40 + 8'(i));
    neg();
    drain(60, "wrap");
    chk("wrap_word_cnt16", word_cnt, 17);
    chk("wrap_word_cnt4", w4_word_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
